inv_sub_bytes_seq: RTL

//  AES InvSubBytes engine for the decrypt datapath. Applies the inverse S-box to all 16 bytes of a 128-bit state.
//  Per byte: inverse affine transform, then GF(2^8) multiplicative inverse mod x^8+x^4+x^3+x+1 (0x11B), with inv(0)=0.
//  The inverse is computed iteratively as b^254 by square-and-multiply, so no lookup table is used.

---
 rtl/aes_gf_pkg.sv | 17 +
 rtl/gf256_mul.sv | 18 +
 rtl/inv_sub_bytes_seq.sv | 91 +++++++++
 3 files changed

// File: rtl/aes_gf_pkg.sv
// aes_gf_pkg: GF(2^8) constants, FSM encoding and AES affine helpers.
package aes_gf_pkg;
   localparam logic [8:0] AES_POLY  = 9'h11B;
   localparam logic [7:0] INV_EXP   = 8'hFE;
   localparam logic [7:0] AFF_C     = 8'h63;
   localparam logic [7:0] INV_AFF_C = 8'h05;
   typedef enum logic [1:0] {IDLE, LOAD, EXP, DONE} fsm_t;
   function automatic logic [7:0] rotl(input logic [7:0] s, input int n);
      return (s << n) | (s >> (8 - n));
   endfunction
   function automatic logic [7:0] inv_affine(input logic [7:0] s);
      return rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ INV_AFF_C;
   endfunction
   function automatic logic [7:0] fwd_affine(input logic [7:0] s);
      return s ^ rotl(s, 1) ^ rotl(s, 2) ^ rotl(s, 3) ^ rotl(s, 4) ^ AFF_C;
   endfunction
endpackage

// File: rtl/gf256_mul.sv
// gf256_mul: combinational GF(2^8) multiply, carry-less product reduced mod 0x11B.
module gf256_mul
   import aes_gf_pkg::*;
(
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   output logic [7:0] p_o
);
   logic [14:0] prod;
   always_comb begin
      prod = '0;
      for (int k = 0; k < 8; k++)
         if (b_i[k]) prod = prod ^ ({7'd0, a_i} << k);
      for (int k = 14; k >= 8; k--)
         if (prod[k]) prod = prod ^ ({6'd0, AES_POLY} << (k - 8));
      p_o = prod[7:0];
   end
endmodule

// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq: byte-serial AES InvSubBytes via b^254 square-and-multiply.
// INV_SBOX_DUAL_EN adds a fwd port selecting forward SubBytes per state.
module inv_sub_bytes_seq
   import aes_gf_pkg::*;
#(
   parameter int N_BYTES = 16
) (
   input  logic                   clk,
   input  logic                   rst,
`ifdef INV_SBOX_DUAL_EN
   input  logic                   fwd,
`endif
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [8*N_BYTES-1:0]   in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [8*N_BYTES-1:0]   out_data,
   output logic                   busy
);
   localparam int IW = $clog2(N_BYTES);
   fsm_t                 state_q, state_d;
   logic [IW-1:0]        byte_idx_q;
   logic [2:0]           bit_cnt_q;
   logic [7:0]           acc_q, acc_d, b_q, sq, sqm, byte_sel, b_load, res;
   logic [8*N_BYTES-1:0] work_q, out_q;
   logic                 fwd_q, last;
`ifdef INV_SBOX_DUAL_EN
   always_ff @(posedge clk)
      if (rst) fwd_q <= 1'b0;
      else if (state_q == IDLE && in_valid) fwd_q <= fwd;
`else
   assign fwd_q = 1'b0;
`endif
   gf256_mul u_sq  (.a_i(acc_q), .b_i(acc_q), .p_o(sq));
   gf256_mul u_mul (.a_i(sq),    .b_i(b_q),   .p_o(sqm));
   always_comb begin
      last     = byte_idx_q == IW'(N_BYTES - 1);
      acc_d    = INV_EXP[bit_cnt_q] ? sqm : sq;
      res      = fwd_q ? fwd_affine(acc_d) : acc_d;
      byte_sel = work_q[{byte_idx_q, 3'b000} +: 8];
      b_load   = fwd_q ? byte_sel : inv_affine(byte_sel);
   end
   always_ff @(posedge clk)
      if (rst) state_q <= IDLE;
      else state_q <= state_d;
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: state_d = in_valid ? LOAD : IDLE;
         LOAD: state_d = EXP;
         EXP:  state_d = bit_cnt_q != 3'd0 ? EXP : last ? DONE : LOAD;
         DONE: state_d = out_ready ? IDLE : DONE;
      endcase
   end
   always_comb begin
      in_ready  = state_q == IDLE;
      out_valid = state_q == DONE;
      busy      = state_q == LOAD || state_q == EXP;
      out_data  = out_q;
   end
   always_ff @(posedge clk)
      if (rst) begin
         byte_idx_q <= '0;
         bit_cnt_q  <= '0;
         acc_q      <= 8'h01;
         b_q        <= '0;
         work_q     <= '0;
         out_q      <= '0;
      end else
         case (state_q)
            IDLE: if (in_valid) begin
               work_q     <= in_data;
               byte_idx_q <= '0;
            end
            LOAD: begin
               b_q       <= b_load;
               acc_q     <= 8'h01;
               bit_cnt_q <= 3'd7;
            end
            EXP: begin
               acc_q     <= acc_d;
               bit_cnt_q <= bit_cnt_q - 3'd1;
               if (bit_cnt_q == 3'd0) begin
                  out_q[{byte_idx_q, 3'b000} +: 8] <= res;
                  if (!last) byte_idx_q <= byte_idx_q + 1'b1;
               end
            end
            default: ;
         endcase
endmodule
